median_scan_ctrl: RTL and testbench

//  Sequencer for the 3x3 median filter datapath. Raster-scans a greyscale image held in a

---
 rtl/median_pkg.sv | 24 ++
 rtl/median_win_reg.sv | 55 +++++
 rtl/median_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_median_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median filter front end.
// Latency: none (declarations only).
// Backpressure: n/a.
package median_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int WIN_N     = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    FETCH1,
    FETCH2,
    LOAD,
    EMIT,
    DONE
  } state_t;

  // Flat index of window pixel (row, col), row-major from the top-left corner.
  function automatic int win_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/median_win_reg.sv
// 3x3 window register array with a two-entry staging column and column shift.
// Latency: a column loaded by 'load' appears on win_data the cycle after.
// Backpressure: none; contents only move on cap0/cap1/load/clr strobes.
module median_win_reg
  import median_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap0,
  input  logic                   cap1,
  input  logic                   load,
  input  logic                   clr,
  input  logic [PIX_W-1:0]       rd_data,
  output logic [WIN_N*PIX_W-1:0] win_data
);

  logic [PIX_W-1:0] stg0;
  logic [PIX_W-1:0] stg1;
  logic [PIX_W-1:0] pix [WIN_N];

  // Stage the top two pixels of a column, then shift the full column in from the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg0 <= '0;
      stg1 <= '0;
      for (int i = 0; i < WIN_N; i++) pix[i] <= '0;
    end else if (clr) begin
      stg0 <= '0;
      stg1 <= '0;
      for (int i = 0; i < WIN_N; i++) pix[i] <= '0;
    end else begin
      if (cap0) stg0 <= rd_data;
      if (cap1) stg1 <= rd_data;
      if (load) begin
        for (int r = 0; r < 3; r++) begin
          pix[win_idx(r, 0)] <= pix[win_idx(r, 1)];
          pix[win_idx(r, 1)] <= pix[win_idx(r, 2)];
        end
        // Third pixel of the column arrives straight from the RAM this cycle.
        pix[win_idx(0, 2)] <= stg0;
        pix[win_idx(1, 2)] <= stg1;
        pix[win_idx(2, 2)] <= rd_data;
      end
    end
  end

  // Flatten the array with p0 in the least significant slot.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN_N; i++) win_data[i*PIX_W +: PIX_W] = pix[i];
  end

endmodule

// File: rtl/median_scan_ctrl.sv
// Raster-scan sequencer: reads a frame from single-port RAM and emits 3x3 windows.
// Latency: 4 cycles per column; first window valid 12 cycles after start is sampled.
// Backpressure: EMIT holds window/row/col and issues no reads until win_ready.
module median_scan_ctrl
  import median_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [PIX_W-1:0]       mem_rd_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [WIN_N*PIX_W-1:0] win_data,
  output logic [ADDR_W-1:0]      win_row,
  output logic [ADDR_W-1:0]      win_col
);

  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 3);

  state_t            state;
  logic [ADDR_W-1:0] c;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] row_base;   // r*IMG_W, kept by accumulation
  logic [ADDR_W-1:0] col_addr;   // row_base + c, address of the column's top pixel
  logic              cap0;
  logic              cap1;
  logic              load;
  logic              clr;

  // Window-register strobes decoded from the current state.
  always_comb begin
    cap0 = 1'b0;
    cap1 = 1'b0;
    load = 1'b0;
    clr  = 1'b0;
    case (state)
      IDLE:    clr  = start;
      FETCH1:  cap0 = 1'b1;
      FETCH2:  cap1 = 1'b1;
      LOAD:    load = 1'b1;
      EMIT:    clr  = win_ready && (c == LAST_COL) && (r < LAST_ROW);
      default: ;
    endcase
  end

  // Sequencer: counters, incremental addressing and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c         <= '0;
      r         <= '0;
      row_base  <= '0;
      col_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH0;
            busy      <= 1'b1;
            c         <= '0;
            r         <= '0;
            row_base  <= '0;
            col_addr  <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
          end
        end
        FETCH0: begin
          state    <= FETCH1;
          mem_addr <= mem_addr + IMG_W_A;
        end
        FETCH1: begin
          state    <= FETCH2;
          mem_addr <= mem_addr + IMG_W_A;
        end
        FETCH2: begin
          state     <= LOAD;
          mem_rd_en <= 1'b0;
        end
        LOAD: begin
          if (c >= 2'd2) begin
            state     <= EMIT;
            win_valid <= 1'b1;
            win_row   <= r;
            win_col   <= c - 2'd2;
          end else begin
            state     <= FETCH0;
            c         <= c + 1'b1;
            col_addr  <= col_addr + 1'b1;
            mem_addr  <= col_addr + 1'b1;
            mem_rd_en <= 1'b1;
          end
        end
        EMIT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (c < LAST_COL) begin
              state     <= FETCH0;
              c         <= c + 1'b1;
              col_addr  <= col_addr + 1'b1;
              mem_addr  <= col_addr + 1'b1;
              mem_rd_en <= 1'b1;
            end else if (r < LAST_ROW) begin
              // Next row band: window is cleared and three columns are reloaded.
              state     <= FETCH0;
              r         <= r + 1'b1;
              c         <= '0;
              row_base  <= row_base + IMG_W_A;
              col_addr  <= row_base + IMG_W_A;
              mem_addr  <= row_base + IMG_W_A;
              mem_rd_en <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  median_win_reg #(
    .PIX_W(PIX_W)
  ) u_win_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .cap0    (cap0),
    .cap1    (cap1),
    .load    (load),
    .clr     (clr),
    .rd_data (mem_rd_data),
    .win_data(win_data)
  );

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Bench for median_scan_ctrl on a 6x5 frame with a behavioural RAM and a window scoreboard.
// Latency: n/a.
// Backpressure: win_ready forced or randomised by the bench.
module tb_median_scan_ctrl;

  localparam int PIX_W  = 8;
  localparam int IMG_W  = 6;
  localparam int IMG_H  = 5;
  localparam int ADDR_W = 5;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);
  localparam int DW     = 9 * PIX_W;

  typedef struct packed {
    logic [DW-1:0]     data;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
  } win_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rdy_force = 1'b0;
  logic              rdy_rnd = 1'b0;
  logic              rnd_en = 1'b0;
  logic              busy, done, mem_rd_en, win_valid, win_ready;
  logic [ADDR_W-1:0] mem_addr, win_row, win_col;
  logic [PIX_W-1:0]  mem_rd_data = '0;
  logic [DW-1:0]     win_data;
  logic [PIX_W-1:0]  img [NPIX];
  win_t              sb [$];
  int                n_chk = 0;
  int                n_pass = 0;
  int                win_cnt = 0;
  int                done_cnt = 0;

  always #5 clk = ~clk;

  assign win_ready = rnd_en ? rdy_rnd : rdy_force;

  median_scan_ctrl #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Synchronous single-port RAM: data one cycle after the read strobe.
  always begin
    logic [ADDR_W-1:0] a;
    @(posedge clk);
    if (mem_rd_en) begin
      a = mem_addr;
      #1 mem_rd_data = (int'(a) < NPIX) ? img[a] : '0;
    end
  end

  // Random ready, changed just after each rising edge.
  always begin
    @(posedge clk);
    #1 rdy_rnd = 1'($urandom_range(0, 1));
  end

  // Scoreboard and done monitor.
  always @(negedge clk) begin
    win_t e;
    if (rst_n && win_valid && win_ready) begin
      check("sb_nonempty", DW'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("win_data", win_data, e.data);
        check("win_row", win_row, e.row);
        check("win_col", win_col, e.col);
      end
      win_cnt++;
    end
    if (rst_n && done) begin
      done_cnt++;
      check("busy_in_done", busy, 0);
    end
  end

  task automatic push_frame();
    win_t w;
    for (int r = 0; r <= IMG_H - 3; r++) begin
      for (int c = 0; c <= IMG_W - 3; c++) begin
        w.row  = ADDR_W'(r);
        w.col  = ADDR_W'(c);
        w.data = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w.data[(i*3+j)*PIX_W +: PIX_W] = img[(r+i)*IMG_W + c + j];
        sb.push_back(w);
      end
    end
  endtask

  // Returns just after the edge that samples start.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_wins(input int base, input int n, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (win_cnt - base >= n) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_done(input int db, input int wb);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt != db) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    repeat (6) @(negedge clk);
    check("done_once", DW'(done_cnt - db), 1);
    check("win_count", DW'(win_cnt - wb), NWIN);
    check("sb_drained", DW'(sb.size()), 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [DW-1:0]     snap_d;
    logic [DW-1:0]     ramp0;
    logic [ADDR_W-1:0] snap_r, snap_c;
    int                wb, db, wb2, cyc;
    bit                ok;

    for (int i = 0; i < NPIX; i++) img[i] = PIX_W'(i);

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", win_valid, 0);
    check("rst_data", win_data, 0);
    check("rst_row", win_row, 0);
    check("rst_col", win_col, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy0", busy, 0);
    check("idle_valid0", win_valid, 0);
    check("idle_rd_en0", mem_rd_en, 0);

    // Ramp image, ready always high
    rdy_force = 1'b1;
    wb = win_cnt;
    db = done_cnt;
    push_frame();
    pulse_start();
    check("busy_after_start", busy, 1);
    cyc = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (win_valid) begin
        cyc = k;
        break;
      end
    end
    check("first_valid_lat", DW'(cyc), 12);
    ramp0 = {8'd14, 8'd13, 8'd12, 8'd8, 8'd7, 8'd6, 8'd2, 8'd1, 8'd0};
    check("ramp_first", win_data, ramp0);
    wait_done(db, wb);

    // Backpressure on the first window
    @(posedge clk);
    #1 rdy_force = 1'b0;
    wb = win_cnt;
    db = done_cnt;
    push_frame();
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", ok, 1);
    snap_d = win_data;
    snap_r = win_row;
    snap_c = win_col;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", win_valid, 1);
      check("bp_data_stable", win_data, snap_d);
      check("bp_row_stable", win_row, snap_r);
      check("bp_col_stable", win_col, snap_c);
      check("bp_no_read", mem_rd_en, 0);
    end
    @(posedge clk);
    #1 rdy_force = 1'b1;
    wb2 = win_cnt;
    @(posedge clk);
    @(negedge clk);
    check("bp_accept_once", DW'(win_cnt - wb2), 1);
    check("bp_valid_drop", win_valid, 0);
    wait_done(db, wb);

    // Random images, random ready
    rnd_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = PIX_W'($urandom);
      wb = win_cnt;
      db = done_cnt;
      push_frame();
      pulse_start();
      wait_done(db, wb);
    end
    rnd_en = 1'b0;

    // Reset mid-frame, then rescan
    wb = win_cnt;
    db = done_cnt;
    push_frame();
    pulse_start();
    wait_wins(wb, 5, "mid_reached");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", win_valid, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_data", win_data, 0);
    check("abort_row", win_row, 0);
    check("abort_col", win_col, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", DW'(done_cnt - db), 0);
    check("abort_idle", busy, 0);
    wb = win_cnt;
    db = done_cnt;
    push_frame();
    pulse_start();
    wait_done(db, wb);

    // Start pulses while busy are ignored
    wb = win_cnt;
    db = done_cnt;
    push_frame();
    pulse_start();
    wait_wins(wb, 3, "busy_reach3");
    pulse_start();
    wait_wins(wb, 7, "busy_reach7");
    pulse_start();
    wait_done(db, wb);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
